// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq - iterative restoring divider for DIV/DIVU in the EX stage.
//
// One quotient bit is produced per clock. While a divide is outstanding the
// block raises stallreq_o so IF/ID/EX stay frozen; when it finishes it presents
// quotient (LO) and remainder (HI) with ready_o for as long as hold_i keeps EX
// frozen.
//
// Ports:
//   clk          pipeline clock, rising edge
//   rst          synchronous reset, active low
//   start_i      level request, held by EX while the divide sits in EX
//   signed_i     1 = DIV (two's complement), 0 = DIVU
//   dividend_i   dividend (rs), sampled on accept
//   divisor_i    divisor (rt), sampled on accept
//   annul_i      flush/cancel, aborts any operation, beats start_i
//   hold_i       EX frozen by another source; keep result presented
//   stallreq_o   stall request to CTRL (combinational)
//   ready_o      quotient_o/remainder_o valid
//   quotient_o   quotient to LO
//   remainder_o  remainder to HI
// -----------------------------------------------------------------------------
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             annul_i,
    input  logic             hold_i,
    output logic             stallreq_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DZ   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      cnt_reg;
    logic               neg_q_reg, neg_r_reg;
    logic [WIDTH-1:0]   divisor_reg;
    // {remainder, quotient}; for a zero divisor the low half carries the raw
    // dividend so the DZ cycle can present it without a separate register.
    logic [2*WIDTH-1:0] work_reg;
    logic [WIDTH-1:0]   quotient_reg, remainder_reg;

    logic               accept;
    logic               divisor_zero;
    logic [WIDTH-1:0]   dividend_mag, divisor_mag;
    logic [2*WIDTH-1:0] shifted;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] work_iter;

    assign accept       = start_i & ~annul_i;
    assign divisor_zero = (divisor_i == '0);
    assign dividend_mag = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
    assign divisor_mag  = (signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;

    // The shifted partial remainder needs WIDTH+1 bits (work_reg[2W-1:W-1]);
    // since rem < divisor the trial result always fits WIDTH bits when it
    // is non-negative, so its top bit is a clean borrow flag.
    assign shifted   = {work_reg[2*WIDTH-2:0], 1'b0};
    assign trial     = work_reg[2*WIDTH-1:WIDTH-1] - {1'b0, divisor_reg};
    assign work_iter = trial[WIDTH] ? shifted
                                    : {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = divisor_zero ? DZ : CALC;
            CALC: if (cnt_reg == CNT_LAST) state_next = DONE;
            DZ:   state_next = DONE;
            DONE: if (!hold_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (annul_i) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            divisor_reg   <= '0;
            work_reg      <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        neg_q_reg   <= signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                        neg_r_reg   <= signed_i & dividend_i[WIDTH-1];
                        divisor_reg <= divisor_mag;
                        work_reg    <= {{WIDTH{1'b0}}, divisor_zero ? dividend_i : dividend_mag};
                        cnt_reg     <= '0;
                    end
                end
                CALC: begin
                    if (!annul_i) begin
                        work_reg <= work_iter;
                        cnt_reg  <= cnt_reg + CW'(1);
                        // Final iteration: sign-correct straight into the outputs.
                        if (cnt_reg == CNT_LAST) begin
                            quotient_reg  <= neg_q_reg ? -work_iter[WIDTH-1:0]
                                                       :  work_iter[WIDTH-1:0];
                            remainder_reg <= neg_r_reg ? -work_iter[2*WIDTH-1:WIDTH]
                                                       :  work_iter[2*WIDTH-1:WIDTH];
                        end
                    end
                end
                DZ: begin
                    if (!annul_i) begin
                        quotient_reg  <= '1;
                        remainder_reg <= work_reg[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign stallreq_o  = rst & start_i & ~annul_i & (state_reg != DONE);
    assign ready_o     = (state_reg == DONE);
    assign quotient_o  = quotient_reg;
    assign remainder_o = remainder_reg;

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, signed_i, annul_i, hold_i;
    logic [31:0] dividend_i, divisor_i;
    logic        stallreq_o, ready_o;
    logic [31:0] quotient_o, remainder_o;

    always #5 clk = ~clk;

    div_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i), .annul_i(annul_i),
        .hold_i(hold_i), .stallreq_o(stallreq_o), .ready_o(ready_o),
        .quotient_o(quotient_o), .remainder_o(remainder_o)
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
        int          hold;
    } vec_t;

    exp_t        sb[$];
    vec_t        vt[9];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_q, last_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one divide, measure latency and stall length, compare result from
    // the scoreboard, optionally hold the result, and return one cycle after
    // DONE has been left (DUT back in IDLE).
    task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eq,
                           input logic [31:0] er, input int elat, input int hold_n);
        exp_t e;
        int   edges, stalls;
        signed_i   = s;
        dividend_i = a;
        divisor_i  = b;
        start_i    = 1'b1;
        sb.push_back('{eq, er});
        edges  = 0;
        stalls = 0;
        while (ready_o !== 1'b1 && edges < 200) begin
            @(negedge clk);
            if (stallreq_o === 1'b1) stalls++;
            @(posedge clk); #1;
            edges++;
            // Operands change while busy; the latched copies must be used.
            if (edges == 1) begin
                dividend_i = $urandom;
                divisor_i  = $urandom;
                signed_i   = ~s;
            end
        end
        check({tag, " latency"}, 32'(edges), 32'(elat));
        check({tag, " stall cycles"}, 32'(stalls), 32'(elat));
        if (ready_o === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, " quotient"}, quotient_o, e.q);
            check({tag, " remainder"}, remainder_o, e.r);
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL %s ready: timeout or empty scoreboard, ready=%b queued=%0d", tag, ready_o, sb.size());
            e = '{eq, er};
        end
        check({tag, " stallreq in DONE"}, {31'b0, stallreq_o}, 32'd0);
        hold_i = (hold_n > 0);
        for (int i = 0; i < hold_n; i++) begin
            @(posedge clk); #1;
            check({tag, " ready held"}, {31'b0, ready_o}, 32'd1);
            check({tag, " quotient held"}, quotient_o, e.q);
            check({tag, " remainder held"}, remainder_o, e.r);
        end
        hold_i  = 1'b0;
        start_i = 1'b0;
        @(posedge clk); #1;
        check({tag, " ready drops"}, {31'b0, ready_o}, 32'd0);
        check({tag, " quotient kept in IDLE"}, quotient_o, e.q);
        last_q = e.q;
        last_r = e.r;
        $display("div %s: s=%b %h / %h -> q=%h r=%h lat=%0d", tag, s, a, b, e.q, e.r, edges);
    endtask

    initial begin
        int          seen;
        logic [31:0] ra, rb, mq, mr;
        logic        rs;

        vt[0] = '{1'b0, 32'd100,        32'd7,          32'h0000000E, 32'd2,        33, 0};
        vt[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD, 32'hFFFFFFFF, 33, 0};
        vt[2] = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD, 32'd1,        33, 0};
        vt[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'd0,        33, 0};
        vt[4] = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC, 32'd1,        33, 0};
        vt[5] = '{1'b0, 32'h00001234,   32'd0,          32'hFFFFFFFF, 32'h1234,     2,  0};
        vt[6] = '{1'b1, 32'h00001234,   32'd0,          32'hFFFFFFFF, 32'h1234,     2,  0};
        vt[7] = '{1'b1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF, 32'hFFFFFFF9, 2,  3};
        vt[8] = '{1'b0, 32'hFFFFFFFF,   32'd16,         32'h0FFFFFFF, 32'd15,       33, 0};

        rst = 1'b0; start_i = 1'b1; signed_i = 1'b0; annul_i = 1'b0; hold_i = 1'b0;
        dividend_i = 32'd5; divisor_i = 32'd1;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", {31'b0, ready_o}, 32'd0);
        check("reset quotient", quotient_o, 32'd0);
        check("reset remainder", remainder_o, 32'd0);
        check("reset stallreq forced low", {31'b0, stallreq_o}, 32'd0);
        start_i = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        // vt[7] holds for 3 cycles, vt[8] follows back-to-back.
        for (int i = 0; i < 9; i++)
            run_div($sformatf("vec%0d", i), vt[i].s, vt[i].a, vt[i].b,
                    vt[i].q, vt[i].r, vt[i].lat, vt[i].hold);

        // Random vectors checked against the language's own division.
        for (int i = 0; i < 4; i++) begin
            rs = i[0];
            ra = $urandom;
            rb = (i < 2) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (rb == 32'd0) rb = 32'd3;
            if (rs && ra == 32'h80000000 && rb == 32'hFFFFFFFF) ra = 32'h7FFFFFFF;
            if (rs) begin
                mq = 32'($signed(ra) / $signed(rb));
                mr = 32'($signed(ra) % $signed(rb));
            end else begin
                mq = ra / rb;
                mr = ra % rb;
            end
            run_div($sformatf("rnd%0d", i), rs, ra, rb, mq, mr, 33, 0);
        end

        // Annul in CALC cycle 10.
        signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7; start_i = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        annul_i = 1'b1;
        @(negedge clk);
        check("annul stallreq", {31'b0, stallreq_o}, 32'd0);
        @(posedge clk); #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        check("annul ready", {31'b0, ready_o}, 32'd0);
        check("annul quotient kept", quotient_o, last_q);
        check("annul remainder kept", remainder_o, last_r);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready_o === 1'b1) seen++;
        end
        check("annul no ready later", 32'(seen), 32'd0);
        $display("annul: aborted 100/7 in CALC cycle 10");
        run_div("post-annul", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, 0);

        // Reset in CALC cycle 20.
        signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7; start_i = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(negedge clk);
        check("midreset stallreq", {31'b0, stallreq_o}, 32'd0);
        @(posedge clk); #1;
        check("midreset ready", {31'b0, ready_o}, 32'd0);
        check("midreset quotient", quotient_o, 32'd0);
        check("midreset remainder", remainder_o, 32'd0);
        rst = 1'b1;
        $display("reset: discarded 100/7 in CALC cycle 20");
        run_div("post-reset", 1'b0, 32'd100, 32'd7, 32'h0000000E, 32'd2, 33, 0);

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Iterative 32-bit divide sequencer for the EX stage of the five-stage MIPS pipeline. It accepts a DIV/DIVU request from EX and runs a one-bit-per-cycle restoring division. While the division runs it holds the pipeline through a stall request that feeds the CTRL stall bus. When it finishes it presents quotient and remainder for the HI/LO write carried down the EX→MEM→WB path.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported.
- clk  input  1  pipeline clock; all state changes on rising edge.
- rst  input  1  synchronous, active-low reset.
- start_i  input  1  level request from EX; held high by EX for as long as the div instruction sits in EX.
- signed_i  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with operands.
- dividend_i  input  32  dividend (rs); sampled on accept.
- divisor_i  input  32  divisor (rt); sampled on accept.
- annul_i  input  1  flush or cancel; aborts any operation.
- hold_i  input  1  EX stage frozen by another stall source; keeps the result presented.
- stallreq_o  output  1  to CTRL; requests a stall of IF/ID/EX.
- ready_o  output  1  quotient_o/remainder_o valid.
- quotient_o  output  32  quotient, to LO.
- remainder_o  output  32  remainder, to HI.

## Operation
- States:
  - IDLE: waiting for a request.
  - CALC: iterating.
  - DZ: divide by zero.
  - DONE: result presented.
- IDLE:
  - When start_i=1 and annul_i=0, the block latches signed_i, |dividend| and |divisor|.
  - Magnitudes are taken only when signed_i=1 and the operand MSB is 1. Otherwise operands pass unchanged.
  - The block also latches the quotient sign (dividend MSB xor divisor MSB, signed only) and the remainder sign (dividend MSB, signed only).
  - Next state is DZ if divisor_i==0, else CALC. The iteration counter clears to 0.
- CALC:
  - 64-bit working register {rem[31:0], quo[31:0]}. It initialises to {32'b0, |dividend|}.
  - Each cycle: shift left 1 and form trial = rem_shifted − |divisor| in 33 bits.
  - If trial is non-negative: rem = trial[31:0] and the quotient LSB is 1. Otherwise keep rem_shifted and the quotient LSB is 0.
  - The counter increments. After the iteration with counter==31, go to DONE.
- DONE entry:
  - quotient_o = neg_q ? −quo : quo.
  - remainder_o = neg_r ? −rem : rem.
  - Both are 32-bit two's complement and wrap modulo 2^32. Example: 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0.
- DZ: one cycle. It loads quotient_o = 32'hFFFF_FFFF and remainder_o = the original dividend_i, then goes to DONE.
- DONE:
  - ready_o=1.
  - If hold_i=1, stay in DONE with outputs stable.
  - If hold_i=0, go to IDLE. The pipeline advances this cycle, so start_i seen in the next IDLE cycle belongs to the next instruction, which allows back-to-back divides.
- stallreq_o = start_i & ~annul_i & (state != DONE). It is combinational, so it is high in the accept cycle.
- annul_i=1 in any state: next state is IDLE, ready_o is not asserted, and quotient_o/remainder_o keep their last values. annul_i has priority over start_i.
- Operands that change while busy are ignored. Only the values latched in IDLE are used.

## Timing
- Reset (rst=0 on an edge):
  - State becomes IDLE and the counter clears.
  - ready_o=0, quotient_o=0, remainder_o=0.
  - stallreq_o is forced to 0 while rst=0.
- Normal latency: start accepted at edge T (IDLE) → 32 CALC cycles → ready_o high in the cycle after edge T+33. stallreq_o is high from T until DONE.
- Divide by zero: accept at T → DZ → ready_o high after edge T+2.
- ready_o stays high for exactly one cycle when hold_i=0, or extends for as long as hold_i=1.
- Reset mid-CALC: state returns to IDLE at that edge with no partial result visible. A new request is accepted on the first edge with rst=1.
- Simultaneous annul_i and counter==31: annul wins and DONE is not entered.

## Test plan
- DIVU: 100 / 7 → ready_o after 33 edges; quotient 14 (0x0E), remainder 2; stallreq_o high for exactly 33 cycles.
- DIV signed operands:
  - −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - 7 / −2 → quotient 0xFFFFFFFD, remainder 1.
  - 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Divide by zero: 0x1234 / 0 (both signs) → ready_o after 2 edges; quotient 0xFFFFFFFF, remainder 0x1234.
- annul_i pulse in CALC cycle 10 → IDLE next cycle, no ready_o, stallreq_o low. A following 9 / 3 request completes normally with quotient 3, remainder 0.
- hold_i=1 for 3 cycles in DONE → ready_o held 4 cycles with stable outputs. Then back-to-back 0xFFFFFFFF / 16 (DIVU) → quotient 0x0FFFFFFF, remainder 15, 33 cycles later.
- rst=0 in CALC cycle 20 → all outputs 0 on the next cycle; operation discarded; a fresh request after reset meets normal latency.
